ascon_perm_engine: RTL and testbench

Iterative ASCON permutation engine. Applies p^a (12 rounds) or p^b (6 rounds) to a 320-bit state, one round per clock. It sits directly upstream of the state register: its round logic writes into an internal reg_state instance. That register's output is looped back as the next round's input and exported as the permuted state. A start/busy/done handshake lets the mode FSM launch permutations back-to-back.

---
 rtl/ascon_pack.sv | 35 +++
 rtl/reg_state.sv | 30 +++
 rtl/ascon_perm_engine.sv | 138 +++++++++++++
 tb/tb_ascon_perm_engine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// ---------------------------------------------------------------------------
// ascon_pack
// Shared types and constants for the ASCON permutation datapath.
//   type_state     : 320-bit state as five 64-bit words, index 0 = x0
//   type_round_cnt : 4-bit round index (valid values 0..11)
//   type_fsm       : permutation engine control states
//   ROUND_CONST    : round constants rc[0..11]
//   SBOX           : 5-bit S-box, input/output bit 4 = x0 slice bit
// ---------------------------------------------------------------------------
package ascon_pack;

    typedef logic [0:4][63:0] type_state;
    typedef logic [3:0]       type_round_cnt;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } type_fsm;

    localparam type_round_cnt LAST_ROUND = 4'd11;

    localparam logic [7:0] ROUND_CONST [0:11] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

endpackage

// File: rtl/reg_state.sv
// ---------------------------------------------------------------------------
// reg_state
// 320-bit ASCON state register with load enable.
//   clock_i  : clock
//   resetb_i : asynchronous active-low reset, clears the state to zero
//   enable   : load state_d on the rising edge
//   state_d  : next state
//   state_q  : registered state
// ---------------------------------------------------------------------------
module reg_state
    import ascon_pack::*;
(
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      enable,
    input  type_state state_d,
    output type_state state_q
);

    // NOTE: this is a plain flop bank, not a RAM, so clearing it on reset is
    // cheap and guarantees a known all-zero state after an aborted run.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= '0;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// ---------------------------------------------------------------------------
// ascon_perm_engine
// Iterative ASCON permutation: one round (pc -> ps -> pl) per clock, p^a or
// p^b selected at launch. The round output is written into reg_state, whose
// output loops back as the next round input and is exported as state_o.
//   clock_i  : clock
//   resetb_i : asynchronous active-low reset
//   start_i  : launch request, honoured in IDLE and DONE
//   mode_b_i : 0 = p^a, 1 = p^b; sampled with start_i
//   state_i  : input state x0..x4; sampled with start_i
//   state_o  : permuted state, held until the next launch
//   busy_o   : high while rounds are in progress
//   done_o   : one-cycle pulse when state_o is final
// ---------------------------------------------------------------------------
module ascon_perm_engine
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
)(
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      start_i,
    input  logic      mode_b_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam type_round_cnt START_A = type_round_cnt'(12 - ROUNDS_A);
    localparam type_round_cnt START_B = type_round_cnt'(12 - ROUNDS_B);

    type_fsm       fsm;
    type_round_cnt round_cnt;
    type_round_cnt start_idx;
    type_round_cnt round_idx;
    logic          launch;
    logic          reg_enable;
    logic [7:0]    round_const;
    type_state     round_in;
    type_state     after_pc;
    type_state     after_ps;
    type_state     round_out;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        logic [127:0] t;
        t = {v, v} >> n;
        return t[63:0];
    endfunction

    // A launch is accepted whenever no permutation is running, including
    // the DONE cycle, which gives back-to-back operation.
    assign start_idx  = mode_b_i ? START_B : START_A;
    assign launch     = start_i && (fsm != ST_RUN);
    assign round_in   = launch ? state_i   : state_o;
    assign round_idx  = launch ? start_idx : round_cnt;
    assign reg_enable = launch || (fsm == ST_RUN);

    // Indices 12..15 cannot occur but decode to a zero constant.
    assign round_const = (round_idx <= LAST_ROUND) ? ROUND_CONST[round_idx] : 8'h00;

    // NOTE: every always_comb output gets a full default assignment first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        after_pc         = round_in;
        after_pc[2][7:0] = round_in[2][7:0] ^ round_const;
    end

    // Substitution layer: the S-box is applied to each vertical bit slice.
    always_comb begin
        after_ps = '0;
        for (int i = 0; i < 64; i++) begin
            {after_ps[0][i], after_ps[1][i], after_ps[2][i], after_ps[3][i], after_ps[4][i]} =
                SBOX[{after_pc[0][i], after_pc[1][i], after_pc[2][i], after_pc[3][i], after_pc[4][i]}];
        end
    end

    // Linear diffusion layer.
    assign round_out[0] = after_ps[0] ^ ror64(after_ps[0], 19) ^ ror64(after_ps[0], 28);
    assign round_out[1] = after_ps[1] ^ ror64(after_ps[1], 61) ^ ror64(after_ps[1], 39);
    assign round_out[2] = after_ps[2] ^ ror64(after_ps[2],  1) ^ ror64(after_ps[2],  6);
    assign round_out[3] = after_ps[3] ^ ror64(after_ps[3], 10) ^ ror64(after_ps[3], 17);
    assign round_out[4] = after_ps[4] ^ ror64(after_ps[4],  7) ^ ror64(after_ps[4], 41);

    reg_state u_reg_state (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .enable   (reg_enable),
        .state_d  (round_out),
        .state_q  (state_o)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm       <= ST_IDLE;
            round_cnt <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (fsm)
                ST_RUN: begin
                    if (round_cnt == LAST_ROUND) begin
                        fsm       <= ST_DONE;
                        round_cnt <= '0;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                default: begin
                    // IDLE and DONE behave alike: launch or rest in IDLE.
                    if (start_i) begin
                        if (start_idx == LAST_ROUND) begin
                            fsm       <= ST_DONE;
                            round_cnt <= '0;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                        end else begin
                            fsm       <= ST_RUN;
                            round_cnt <= start_idx + 4'd1;
                            busy_o    <= 1'b1;
                            done_o    <= 1'b0;
                        end
                    end else begin
                        fsm    <= ST_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_engine.sv
// ---------------------------------------------------------------------------
// tb_ascon_perm_engine
// Directed self-checking bench for ascon_perm_engine. Expected states come
// from a bit-sliced reference model of the ASCON round (Boolean S-box
// equations, shift-based rotations, arithmetic round constants).
// ---------------------------------------------------------------------------
module tb_ascon_perm_engine;

    typedef logic [0:4][63:0] state_t;
    typedef logic [63:0]      w64_t;

    logic   clock_i = 1'b0;
    logic   resetb_i;
    logic   start_i;
    logic   mode_b_i;
    state_t state_i;
    state_t state_o;
    logic   busy_o;
    logic   done_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rc_tab [0:11] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    localparam state_t S_INIT = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'h0};
    localparam state_t S_ZERO = '0;
    localparam state_t S_PB   = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                 64'hdeadbeefcafef00d, 64'h0f1e2d3c4b5a6978,
                                 64'h8000000000000001};
    localparam state_t S_B2B1 = {64'hffffffffffffffff, 64'h0, 64'haaaaaaaaaaaaaaaa,
                                 64'h5555555555555555, 64'h1};
    localparam state_t S_B2B2 = {64'h1111111111111111, 64'h2222222222222222,
                                 64'h3333333333333333, 64'h4444444444444444,
                                 64'h5555555555555555};

    always #5 clock_i = ~clock_i;

    ascon_perm_engine dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .start_i  (start_i),
        .mode_b_i (mode_b_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    // ---------------- reference model ----------------
    function automatic w64_t rot(input w64_t v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic state_t model_round(input state_t s, input int r);
        w64_t x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x2 = x2 ^ {56'h0, 4'(15 - r), 4'(r)};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ rot(x0, 19) ^ rot(x0, 28);
        x1 = x1 ^ rot(x1, 61) ^ rot(x1, 39);
        x2 = x2 ^ rot(x2, 1)  ^ rot(x2, 6);
        x3 = x3 ^ rot(x3, 10) ^ rot(x3, 17);
        x4 = x4 ^ rot(x4, 7)  ^ rot(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic state_t model_perm(input state_t s, input int first);
        state_t x;
        x = s;
        for (int r = first; r < 12; r++) x = model_round(x, r);
        return x;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
        return s;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t obs, input state_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    // Drive a launch, check the first round constant, then move to the cycle
    // after the launch edge with start_i dropped and state_i scrambled.
    task automatic launch(input state_t s, input logic mode);
        start_i  = 1'b1;
        mode_b_i = mode;
        state_i  = s;
        #1;
        chk_byte("rc_launch", dut.round_const, rc_tab[mode ? 6 : 0]);
        @(negedge clock_i);
        start_i = 1'b0;
        state_i = rand_state();
    endtask

    // Walk the running cycles of a permutation that started at round first.
    task automatic run_cycles(input int first, input bit garbage);
        int n;
        n = 11 - first;
        for (int i = 0; i < n; i++) begin
            chk_bit("busy_run", busy_o, 1'b1);
            chk_bit("done_run", done_o, 1'b0);
            chk_byte("rc_seq", dut.round_const, rc_tab[first + 1 + i]);
            if (garbage && (i < n - 1) && (i % 2 == 0)) begin
                start_i  = 1'b1;
                mode_b_i = 1'($urandom);
                state_i  = rand_state();
            end else begin
                start_i = 1'b0;
            end
            @(negedge clock_i);
        end
    endtask

    task automatic expect_done(input state_t exp);
        chk_bit("done_pulse", done_o, 1'b1);
        chk_bit("busy_done", busy_o, 1'b0);
        chk_state("state_final", state_o, exp);
    endtask

    task automatic expect_idle_after(input state_t exp);
        @(negedge clock_i);
        chk_bit("done_single", done_o, 1'b0);
        chk_bit("busy_idle", busy_o, 1'b0);
        chk_state("state_held", state_o, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        state_t exp;

        // Reset with a pending start and random input state.
        resetb_i = 1'b0;
        start_i  = 1'b1;
        mode_b_i = 1'b0;
        state_i  = rand_state();
        repeat (2) @(negedge clock_i);
        chk_state("rst_state", state_o, S_ZERO);
        chk_bit("rst_busy", busy_o, 1'b0);
        chk_bit("rst_done", done_o, 1'b0);

        // Release reset without start: outputs stay quiet.
        start_i  = 1'b0;
        resetb_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_i);
            chk_state("idle_state", state_o, S_ZERO);
            chk_bit("idle_busy", busy_o, 1'b0);
            chk_bit("idle_done", done_o, 1'b0);
        end

        // p^a on the ASCON-128 initial state word.
        exp = model_perm(S_INIT, 0);
        launch(S_INIT, 1'b0);
        run_cycles(0, 1'b0);
        expect_done(exp);
        expect_idle_after(exp);

        // p^b on the all-zero state, round constants 0x96..0x4B.
        exp = model_perm(S_ZERO, 6);
        launch(S_ZERO, 1'b1);
        run_cycles(6, 1'b0);
        expect_done(exp);
        expect_idle_after(exp);

        // p^b on a mixed state.
        exp = model_perm(S_PB, 6);
        launch(S_PB, 1'b1);
        run_cycles(6, 1'b0);
        expect_done(exp);
        expect_idle_after(exp);

        // Back-to-back with ignored start pulses during RUN.
        exp = model_perm(S_B2B1, 0);
        launch(S_B2B1, 1'b0);
        run_cycles(0, 1'b1);
        expect_done(exp);
        exp = model_perm(S_B2B2, 0);
        launch(S_B2B2, 1'b0);
        run_cycles(0, 1'b0);
        expect_done(exp);
        expect_idle_after(exp);

        // Reset in the middle of p^a: immediate abort, then a clean rerun.
        launch(S_INIT, 1'b0);
        repeat (5) @(negedge clock_i);
        resetb_i = 1'b0;
        #1;
        chk_state("abort_state", state_o, S_ZERO);
        chk_bit("abort_busy", busy_o, 1'b0);
        chk_bit("abort_done", done_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            chk_bit("abort_no_done", done_o, 1'b0);
            chk_state("abort_hold", state_o, S_ZERO);
        end
        resetb_i = 1'b1;
        @(negedge clock_i);
        exp = model_perm(S_INIT, 0);
        launch(S_INIT, 1'b0);
        run_cycles(0, 1'b0);
        expect_done(exp);
        expect_idle_after(exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
